// File: rtl/program_loader.sv
// Boot-time loader: streams a byte image into memory from address 0, reads it
// back against a running checksum, then hands the memory port and reset to the CPU.
package program_loader_pkg;
  localparam int REGSIZE = 8;

  typedef enum logic [1:0] {
    MEMORY_STAY  = 2'd0,
    MEMORY_READ  = 2'd1,
    MEMORY_WRITE = 2'd2
  } MEMORY_FLAG_TYPE;
endpackage

module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 LOAD_VALID,
  input  logic [REGSIZE-1:0]   LOAD_DATA,
  input  logic                 LOAD_LAST,
  output logic                 LOAD_READY,
  output logic [REGSIZE-1:0]   address,
  output MEMORY_FLAG_TYPE      rw_flag,
  output logic [REGSIZE-1:0]   write_memory_value,
  input  logic [REGSIZE-1:0]   read_memory_value,
  output logic                 MEM_SELECT,
  output logic                 CPU_RESET,
  output logic                 DONE,
  output logic                 LOAD_ERROR,
  output logic [REGSIZE:0]     LOADED_COUNT
);

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_VERIFY = 3'd1,
    ST_CHECK  = 3'd2,
    ST_RUN    = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic [REGSIZE:0] LAST_ADDR = (REGSIZE+1)'(MEM_DEPTH - 1);

  state_t               state_q, state_d;
  logic [REGSIZE:0]     loaded_count_q, loaded_count_d;
  logic [REGSIZE-1:0]   wsum_q, wsum_d;
  logic [REGSIZE-1:0]   rsum_q, rsum_d;
  logic [REGSIZE-1:0]   vidx_q, vidx_d;
  logic                 load_ready_q, cpu_reset_q, mem_select_q, done_q, load_error_q;
  logic                 xfer;

  assign xfer = (state_q == ST_LOAD) && LOAD_VALID;

  always_comb begin
    state_d        = state_q;
    loaded_count_d = loaded_count_q;
    wsum_d         = wsum_q;
    rsum_d         = rsum_q;
    vidx_d         = vidx_q;
    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          loaded_count_d = loaded_count_q + 1'b1;
          wsum_d         = wsum_q + LOAD_DATA;
          if (LOAD_LAST) begin
            state_d = ST_VERIFY;
            vidx_d  = '0;
            rsum_d  = '0;
          end else if (loaded_count_q == LAST_ADDR) begin
            // Last slot consumed without an end marker: the image cannot fit.
            state_d = ST_ERROR;
          end
        end
      end
      ST_VERIFY: begin
        rsum_d = rsum_q + read_memory_value;
        vidx_d = vidx_q + 1'b1;
        if ({1'b0, vidx_q} == loaded_count_q - 1'b1) state_d = ST_CHECK;
      end
      ST_CHECK: state_d = (rsum_q == wsum_q) ? ST_RUN : ST_ERROR;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_ERROR;
    endcase
  end

  // Status outputs are registered off the next state so they track state_q exactly.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q        <= ST_LOAD;
      loaded_count_q <= '0;
      wsum_q         <= '0;
      rsum_q         <= '0;
      vidx_q         <= '0;
      load_ready_q   <= 1'b1;
      cpu_reset_q    <= 1'b1;
      mem_select_q   <= 1'b0;
      done_q         <= 1'b0;
      load_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      loaded_count_q <= loaded_count_d;
      wsum_q         <= wsum_d;
      rsum_q         <= rsum_d;
      vidx_q         <= vidx_d;
      load_ready_q   <= (state_d == ST_LOAD);
      cpu_reset_q    <= (state_d != ST_RUN);
      mem_select_q   <= (state_d == ST_RUN);
      done_q         <= (state_d == ST_RUN);
      load_error_q   <= (state_d == ST_ERROR);
    end
  end

  always_comb begin
    rw_flag            = MEMORY_STAY;
    address            = '0;
    write_memory_value = '0;
    if (xfer) begin
      rw_flag            = MEMORY_WRITE;
      address            = loaded_count_q[REGSIZE-1:0];
      write_memory_value = LOAD_DATA;
    end else if (state_q == ST_VERIFY) begin
      rw_flag = MEMORY_READ;
      address = vidx_q;
    end
  end

  assign LOAD_READY   = load_ready_q;
  assign CPU_RESET    = cpu_reset_q;
  assign MEM_SELECT   = mem_select_q;
  assign DONE         = done_q;
  assign LOAD_ERROR   = load_error_q;
  assign LOADED_COUNT = loaded_count_q;

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader that sits directly upstream of the CPU and its `memory_unit`. While the CPU is held in reset, it accepts a byte stream over a valid/ready handshake and writes each byte into consecutive memory addresses starting at 0. It then reads the image back and checks it against a running checksum. On success it hands memory ownership to the CPU and releases the CPU's reset; on failure it keeps the CPU held.

## Interface
Parameters:
- `MEM_DEPTH`, default 256: number of addressable memory words; must be ≤ 2^`REGSIZE`.

Ports:
- `CLOCK`  in  1  clock; all state updates on the posedge.
- `RESET`  in  1  reset, synchronous, active-high.
- `LOAD_VALID`  in  1  a byte is offered on `LOAD_DATA`.
- `LOAD_DATA`  in  `REGSIZE`  program byte.
- `LOAD_LAST`  in  1  qualifies the offered byte as the final byte of the image.
- `LOAD_READY`  out  1  loader accepts the offered byte this cycle.
- `address`  out  `REGSIZE`  memory address driven by the loader.
- `rw_flag`  out  `MEMORY_FLAG_TYPE`  one of `MEMORY_STAY`, `MEMORY_READ`, `MEMORY_WRITE`.
- `write_memory_value`  out  `REGSIZE`  memory write data.
- `read_memory_value`  in  `REGSIZE`  memory read data; combinational from `address`.
- `MEM_SELECT`  out  1  0 = loader owns the memory port, 1 = CPU owns it (drives the top-level mux).
- `CPU_RESET`  out  1  reset for the CPU; active-high.
- `DONE`  out  1  image loaded and verified; CPU running.
- `LOAD_ERROR`  out  1  overflow or verify mismatch.
- `LOADED_COUNT`  out  `REGSIZE`+1  number of bytes accepted.

## Operation
States:
- **LOAD**
  - `LOAD_READY`=1.
  - A transfer occurs when `LOAD_VALID`&&`LOAD_READY`. In the same cycle the loader drives `rw_flag`=`MEMORY_WRITE`, `address`=`LOADED_COUNT`[`REGSIZE`-1:0] and `write_memory_value`=`LOAD_DATA`.
  - Without a transfer: `rw_flag`=`MEMORY_STAY`, `address`=0, `write_memory_value`=0.
  - On each transfer: `LOADED_COUNT`+=1 and `wsum`+=`LOAD_DATA` (mod 2^`REGSIZE`).
  - Transfer with `LOAD_LAST`=1 → VERIFY, with index `vidx`=0 and `rsum`=0.
  - Transfer without `LOAD_LAST` at address `MEM_DEPTH`-1 → ERROR (overflow). That byte is still written and counted.
- **VERIFY**
  - `LOAD_READY`=0, `rw_flag`=`MEMORY_READ`, `address`=`vidx`.
  - Each cycle: `rsum`+=`read_memory_value`, `vidx`+=1.
  - When `vidx`==`LOADED_COUNT`-1 → CHECK.
- **CHECK**
  - One cycle, `rw_flag`=`MEMORY_STAY`.
  - `rsum`==`wsum` → RUN, otherwise → ERROR.
- **RUN**
  - `MEM_SELECT`=1, `CPU_RESET`=0, `DONE`=1, `rw_flag`=`MEMORY_STAY`, `address`=0, `LOAD_READY`=0.
  - Terminal until `RESET`.
- **ERROR**
  - `LOAD_ERROR`=1, `CPU_RESET`=1, `MEM_SELECT`=0, `LOAD_READY`=0, `rw_flag`=`MEMORY_STAY`.
  - Terminal until `RESET`.

Rules:
- `LOAD_DATA` and `LOAD_LAST` are ignored unless a transfer occurs.
- `LOAD_VALID` while not in LOAD is ignored; no byte is consumed.
- All sums wrap modulo 2^`REGSIZE`; `LOADED_COUNT` does not wrap (max `MEM_DEPTH`).

## Timing
- Reset (`RESET`=1 at a posedge), next cycle values:
  - state=LOAD, `LOAD_READY`=1, `CPU_RESET`=1, `MEM_SELECT`=0, `DONE`=0, `LOAD_ERROR`=0, `LOADED_COUNT`=0.
  - `wsum`=`rsum`=`vidx`=0, `rw_flag`=`MEMORY_STAY`, `address`=0, `write_memory_value`=0.
- Memory-port outputs are combinational from the state, the handshake and the registers. A write happens at the posedge ending the transfer cycle.
- `RESET` mid-LOAD or mid-VERIFY aborts the operation: the loader restarts at address 0 and memory contents are not cleared. `RESET` in RUN re-asserts `CPU_RESET` at the next cycle.
- Latency for an N-byte image with no stalls:
  - N transfer cycles, then N VERIFY cycles, then 1 CHECK cycle.
  - `CPU_RESET` falls and `DONE` rises in cycle 2N+1 after the first transfer cycle.
  - The CPU first sees `RESET` low at the posedge ending that cycle.
- N=1: VERIFY lasts exactly one cycle (`vidx`=0 is already `LOADED_COUNT`-1).
- `DONE` and `LOAD_ERROR` are never both 1.

## Test plan
- Reset, then stream 0x13, 0x05, 0xF0 with `LAST` on the third byte, no stalls:
  - memory[0..2]=13,05,F0; `LOADED_COUNT`=3; wsum=0x08.
  - VERIFY reads addresses 0,1,2; `DONE`=1 and `CPU_RESET`=0 exactly 7 cycles after the first transfer.
- Same stream with `LOAD_VALID` toggled 1,0,0,1,0,1:
  - writes occur only on valid cycles, with addresses still 0,1,2; final result identical.
- Single byte 0xFF with `LAST`:
  - one write, one verify read at address 0, RUN three cycles after the transfer.
- With `MEM_DEPTH`=256, stream 256 bytes without `LAST`:
  - the 256th byte is written to 0xFF; `LOAD_ERROR`=1 next cycle, `LOADED_COUNT`=256, `CPU_RESET` stays 1, `LOAD_READY`=0.
- Memory model corrupts address 1 after the write (returns 0x06 instead of 0x05):
  - CHECK sees rsum≠wsum → `LOAD_ERROR`=1, `DONE`=0.
- Assert `RESET` after 2 of 3 bytes, then stream 0xAA with `LAST`:
  - address 0 is rewritten with 0xAA; `LOADED_COUNT`=1; RUN reached; memory[1] keeps 0x05.
